// File: rtl/bus_xfer_arbiter.sv
// Round-robin owner of the shared datapath bus. Each grant drives the bus select,
// then pulses a one-hot destination load in a fixed 3-cycle transfer.
module bus_xfer_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned SEL_W = 5,
  parameter int unsigned NREG  = 24
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SEL_W-1:0] src_code,
  input  logic [NREQ*SEL_W-1:0] dst_code,
  output logic [SEL_W-1:0]      bus_sel,
  output logic                  bus_valid,
  output logic [NREG-1:0]       ld_en,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       err,
  output logic [15:0]           xfer_count
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] dst_q, dst_d;
  logic [SEL_W-1:0] bus_sel_q, bus_sel_d;
  logic             bus_valid_q, bus_valid_d;
  logic [NREG-1:0]  ld_en_q, ld_en_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] src_arr [NREQ];
  logic [SEL_W-1:0] dst_arr [NREQ];
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;
  logic [SEL_W-1:0] pick_src;
  logic [SEL_W-1:0] pick_dst;
  logic             pick_legal;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign src_arr[g] = src_code[g*SEL_W +: SEL_W];
    assign dst_arr[g] = dst_code[g*SEL_W +: SEL_W];
  end

  // First requester at or above rr_ptr, wrapping around
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PTR_W'((32'(rr_ptr_q) + i) % NREQ);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_src   = src_arr[pick_idx];
  assign pick_dst   = dst_arr[pick_idx];
  assign pick_legal = (32'(pick_src) < NREG) && (32'(pick_dst) < NREG);

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    dst_d       = dst_q;
    bus_sel_d   = bus_sel_q;
    bus_valid_d = 1'b0;
    ld_en_d     = '0;
    grant_d     = grant_q;
    done_d      = '0;
    err_d       = '0;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d  = NREQ'(1) << pick_idx;
          rr_ptr_d = PTR_W'((32'(pick_idx) + 1) % NREQ);
          dst_d    = pick_dst;
          if (pick_legal) begin
            state_d     = S_DRIVE;
            bus_sel_d   = pick_src;
            bus_valid_d = 1'b1;
          end else begin
            state_d = S_ERR;
            done_d  = NREQ'(1) << pick_idx;
            err_d   = NREQ'(1) << pick_idx;
          end
        end
      end
      S_DRIVE: begin
        state_d     = S_LOAD;
        bus_valid_d = 1'b1;
        ld_en_d     = NREG'(1) << dst_q;
        done_d      = grant_q;
        cnt_d       = cnt_q + CNT_W'(1);
      end
      S_LOAD: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      dst_q       <= '0;
      bus_sel_q   <= '0;
      bus_valid_q <= 1'b0;
      ld_en_q     <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      dst_q       <= dst_d;
      bus_sel_q   <= bus_sel_d;
      bus_valid_q <= bus_valid_d;
      ld_en_q     <= ld_en_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus_sel    = bus_sel_q;
  assign bus_valid  = bus_valid_q;
  assign ld_en      = ld_en_q;
  assign grant      = grant_q;
  assign done       = done_q;
  assign err        = err_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Self-checking bench for bus_xfer_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_bus_xfer_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 5;
  localparam int unsigned NREG  = 24;
  localparam int unsigned PW    = 2;

  typedef struct packed {
    logic [NREQ-1:0]  grant;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic [NREG-1:0]  ld;
    logic [NREQ-1:0]  done;
    logic [NREQ-1:0]  err;
    logic [15:0]      cnt;
  } snap_t;

  logic                  clock = 1'b0;
  logic                  clear;
  logic [NREQ-1:0]       req;
  logic [SEL_W-1:0]      src_a [NREQ];
  logic [SEL_W-1:0]      dst_a [NREQ];
  logic [NREQ*SEL_W-1:0] src_code, dst_code;
  logic [SEL_W-1:0]      bus_sel;
  logic                  bus_valid;
  logic [NREG-1:0]       ld_en;
  logic [NREQ-1:0]       grant, done, err;
  logic [15:0]           xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int               rr_m;
  logic [SEL_W-1:0] sel_m;
  logic [15:0]      cnt_m;

  snap_t obs   [3];
  snap_t exp_s [3];
  int    n_snap;
  int    own;
  bit    lgl;

  bus_xfer_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W), .NREG(NREG)) dut (
    .clock(clock), .clear(clear), .req(req),
    .src_code(src_code), .dst_code(dst_code),
    .bus_sel(bus_sel), .bus_valid(bus_valid), .ld_en(ld_en),
    .grant(grant), .done(done), .err(err), .xfer_count(xfer_count)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_code[i*SEL_W +: SEL_W] = src_a[i];
      dst_code[i*SEL_W +: SEL_W] = dst_a[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic snap_t snap();
    snap_t t;
    t.grant = grant;
    t.sel   = bus_sel;
    t.valid = bus_valid;
    t.ld    = ld_en;
    t.done  = done;
    t.err   = err;
    t.cnt   = xfer_count;
    return t;
  endfunction

  task automatic model_reset();
    rr_m  = 0;
    sel_m = '0;
    cnt_m = '0;
  endtask

  task automatic do_reset();
    req   = '0;
    clear = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    model_reset();
  endtask

  // Present rv, observe the whole transfer, and build the model's expected cycles
  task automatic run_one(input logic [NREQ-1:0] rv, input bit hold);
    logic [SEL_W-1:0] s, d;
    logic [PW-1:0]    oi;
    snap_t            e;
    own = -1;
    for (int i = 0; i < NREQ; i++) begin
      int c = (rr_m + i) % NREQ;
      if (own < 0 && rv[c]) own = c;
    end
    oi   = PW'(own);
    s    = src_a[oi];
    d    = dst_a[oi];
    lgl  = (int'(s) < NREG) && (int'(d) < NREG);
    rr_m = (own + 1) % NREQ;
    req  = rv;
    tick();
    obs[0] = snap();
    if (lgl) begin
      sel_m = s;
      e = '0; e.grant = NREQ'(1) << own; e.sel = s; e.valid = 1'b1; e.cnt = cnt_m;
      exp_s[0] = e;
      tick();
      obs[1] = snap();
      if (!hold) req[oi] = 1'b0;
      cnt_m = cnt_m + 16'd1;
      e.ld = NREG'(1) << d; e.done = NREQ'(1) << own; e.cnt = cnt_m;
      exp_s[1] = e;
      tick();
      obs[2] = snap();
      e = '0; e.sel = s; e.cnt = cnt_m;
      exp_s[2] = e;
      n_snap = 3;
    end else begin
      e = '0; e.grant = NREQ'(1) << own; e.sel = sel_m; e.cnt = cnt_m;
      e.done = NREQ'(1) << own; e.err = NREQ'(1) << own;
      exp_s[0] = e;
      if (!hold) req[oi] = 1'b0;
      tick();
      obs[1] = snap();
      e = '0; e.sel = sel_m; e.cnt = cnt_m;
      exp_s[1] = e;
      n_snap = 2;
    end
  endtask

  task automatic test_reset();
    req = '0;
    for (int i = 0; i < NREQ; i++) begin src_a[i] = '0; dst_a[i] = '0; end
    clear = 1'b0;
    #3;
    n_checks++;
    if (snap() !== '0) begin n_fail++; $display("FAIL reset_async: got %h expected 0", snap()); end
    tick();
    n_checks++;
    if (snap() !== '0) begin n_fail++; $display("FAIL reset_held: got %h expected 0", snap()); end
    clear = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (snap() !== '0) begin n_fail++; $display("FAIL idle_after_reset: got %h expected 0", snap()); end
  endtask

  task automatic test_basic();
    src_a[0] = 5'd21;
    dst_a[0] = 5'd3;
    run_one(4'b0001, 1'b0);
    for (int k = 0; k < n_snap; k++) begin
      n_checks++;
      if (obs[k] !== exp_s[k]) begin
        n_fail++; $display("FAIL basic cyc%0d: got %h expected %h", k + 1, obs[k], exp_s[k]);
      end
    end
    n_checks++;
    if (obs[0].sel !== 5'd21 || obs[0].valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_drive: sel %0d valid %b expected 21 1", obs[0].sel, obs[0].valid);
    end
    n_checks++;
    if (obs[1].ld !== 24'h000008 || obs[1].done !== 4'b0001 || obs[1].cnt !== 16'd1) begin
      n_fail++; $display("FAIL basic_load: ld %h done %b cnt %0d expected 000008 0001 1", obs[1].ld, obs[1].done, obs[1].cnt);
    end
    n_checks++;
    if (obs[2].grant !== 4'b0000) begin
      n_fail++; $display("FAIL basic_release: grant %b expected 0000", obs[2].grant);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin src_a[i] = 5'(i + 1); dst_a[i] = 5'(10 + i); end
    for (int t = 0; t < 5; t++) begin
      run_one(4'b1111, 1'b1);
      n_checks++;
      if (obs[0].grant !== (NREQ'(1) << order[t])) begin
        n_fail++; $display("FAIL rr_order t%0d: grant %b expected owner %0d", t, obs[0].grant, order[t]);
      end
      for (int k = 0; k < n_snap; k++) begin
        n_checks++;
        if (obs[k] !== exp_s[k]) begin
          n_fail++; $display("FAIL rr t%0d cyc%0d: got %h expected %h", t, k + 1, obs[k], exp_s[k]);
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_illegal();
    logic [15:0] c0;
    c0 = cnt_m;
    src_a[2] = 5'd30;
    dst_a[2] = 5'd5;
    run_one(4'b0100, 1'b0);
    for (int k = 0; k < n_snap; k++) begin
      n_checks++;
      if (obs[k] !== exp_s[k]) begin
        n_fail++; $display("FAIL illegal cyc%0d: got %h expected %h", k + 1, obs[k], exp_s[k]);
      end
    end
    n_checks++;
    if (obs[0].err !== 4'b0100 || obs[0].done !== 4'b0100) begin
      n_fail++; $display("FAIL illegal_err: err %b done %b expected 0100 0100", obs[0].err, obs[0].done);
    end
    n_checks++;
    if (obs[0].valid || obs[1].valid || obs[0].ld != '0 || obs[1].ld != '0 || obs[1].cnt !== c0) begin
      n_fail++; $display("FAIL illegal_quiet: valid %b%b ld %h/%h cnt %0d expected 00 0/0 %0d",
                         obs[0].valid, obs[1].valid, obs[0].ld, obs[1].ld, obs[1].cnt, c0);
    end
  endtask

  task automatic test_reset_mid();
    src_a[0] = 5'd20;
    dst_a[0] = 5'd23;
    req = 4'b0001;
    tick();
    n_checks++;
    if (bus_valid !== 1'b1 || bus_sel !== 5'd20) begin
      n_fail++; $display("FAIL mid_drive: valid %b sel %0d expected 1 20", bus_valid, bus_sel);
    end
    #2 clear = 1'b0;
    #1;
    n_checks++;
    if (snap() !== '0) begin n_fail++; $display("FAIL mid_reset_async: got %h expected 0", snap()); end
    tick();
    n_checks++;
    if (snap() !== '0) begin n_fail++; $display("FAIL mid_reset_no_load: got %h expected 0", snap()); end
    clear = 1'b1;
    model_reset();
    src_a[1] = 5'd1;
    dst_a[1] = 5'd2;
    run_one(4'b0011, 1'b0);
    n_checks++;
    if (obs[0].grant !== 4'b0001) begin
      n_fail++; $display("FAIL mid_rr_restart: grant %b expected 0001", obs[0].grant);
    end
    for (int k = 0; k < n_snap; k++) begin
      n_checks++;
      if (obs[k] !== exp_s[k]) begin
        n_fail++; $display("FAIL mid_after cyc%0d: got %h expected %h", k + 1, obs[k], exp_s[k]);
      end
    end
    req = '0;
  endtask

  task automatic test_code_change();
    src_a[0] = 5'd16;
    dst_a[0] = 5'd7;
    req = 4'b0001;
    tick();
    n_checks++;
    if (bus_sel !== 5'd16 || grant !== 4'b0001 || bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL chg_drive: sel %0d grant %b valid %b expected 16 0001 1", bus_sel, grant, bus_valid);
    end
    src_a[0] = 5'd17;
    dst_a[0] = 5'd9;
    tick();
    n_checks++;
    if (bus_sel !== 5'd16 || ld_en !== 24'h000080 || done !== 4'b0001) begin
      n_fail++; $display("FAIL chg_load: sel %0d ld %h done %b expected 16 000080 0001", bus_sel, ld_en, done);
    end
    req = '0;
    tick();
    rr_m  = 1;
    sel_m = 5'd16;
    cnt_m = cnt_m + 16'd1;
    n_checks++;
    if (grant !== 4'b0000 || xfer_count !== cnt_m) begin
      n_fail++; $display("FAIL chg_end: grant %b cnt %0d expected 0000 %0d", grant, xfer_count, cnt_m);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        src_a[i] = 5'($urandom_range(0, 31));
        dst_a[i] = 5'($urandom_range(0, 31));
      end
      run_one(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < n_snap; k++) begin
        n_checks++;
        if (obs[k] !== exp_s[k]) begin
          n_fail++; $display("FAIL random t%0d cyc%0d: got %h expected %h", t, k + 1, obs[k], exp_s[k]);
        end
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 16'hFFFE;
    tick();
    release dut.cnt_q;
    cnt_m = 16'hFFFE;
    n_checks++;
    if (xfer_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL wrap_preload: cnt %h expected fffe", xfer_count);
    end
    src_a[3] = 5'd0;
    dst_a[3] = 5'd0;
    run_one(4'b1000, 1'b0);
    n_checks++;
    if (obs[1].cnt !== 16'hFFFF || obs[1].ld !== 24'h000001) begin
      n_fail++; $display("FAIL wrap_ffff: cnt %h ld %h expected ffff 000001", obs[1].cnt, obs[1].ld);
    end
    run_one(4'b1000, 1'b0);
    n_checks++;
    if (obs[1].cnt !== 16'h0000 || obs[2].cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: cnt %h/%h expected 0000/0000", obs[1].cnt, obs[2].cnt);
    end
    for (int k = 0; k < n_snap; k++) begin
      n_checks++;
      if (obs[k] !== exp_s[k]) begin
        n_fail++; $display("FAIL wrap cyc%0d: got %h expected %h", k + 1, obs[k], exp_s[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_illegal();
    test_reset_mid();
    test_code_change();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer_arbiter.md
Name: bus_xfer_arbiter

Overview:
Sequences every transfer on the shared 32-bit datapath bus. Up to NREQ requesters (control unit, I/O, debug, etc.) each post a source code and a destination code. The arbiter grants one requester at a time in round-robin order and drives the bus-multiplexer select. It then pulses a one-hot register load enable so the selected source is written into the destination register in a fixed 3-cycle transfer.

Parameters:
NREQ, 4, number of requesters (2..8)
SEL_W, 5, width of bus select / register code
NREG, 24, number of valid register codes (0..NREG-1)

Ports:
clock  in  1  rising-edge clock
clear  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester transfer request, level, held until done
src_code  in  NREQ*SEL_W  requester i source code at [i*SEL_W +: SEL_W]
dst_code  in  NREQ*SEL_W  requester i destination code, same packing
bus_sel  out  SEL_W  select to the bus multiplexer
bus_valid  out  1  bus carries a granted source value
ld_en  out  NREG  one-hot destination load enable
grant  out  NREQ  one-hot, identifies the current owner
done  out  NREQ  one-cycle completion pulse to the owner
err  out  NREQ  one-cycle pulse, request rejected (bad code)
xfer_count  out  16  completed legal transfers, wraps at 0xFFFF->0

Behaviour:
- Codes: 0-15 are r0-r15; 16 is hi; 17 is lo; 18 is zhi; 19 is zlo; 20 is pc; 21 is mdr; 22 is inport; 23 is Y. A code >= NREG is illegal.
- Reset (clear=0, asynchronous): state=IDLE, rr_ptr=0, and every output is 0.
- Reset mid-transfer aborts the transfer. No ld_en or done is issued for it.
- All outputs are registered. There are no combinational paths from any input to any output.
- FSM states are IDLE, DRIVE, LOAD, ERR.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the first set req bit, searching upward from rr_ptr with wrap.
  - Latch that requester's src/dst codes and set grant to its bit.
  - Set rr_ptr to granted index + 1 (mod NREQ).
  - If both latched codes are legal, go to DRIVE. Otherwise go to ERR.
- DRIVE (1 cycle): bus_sel=src and bus_valid=1. ld_en=0.
- LOAD (1 cycle):
  - bus_sel=src is held and bus_valid=1.
  - ld_en[dst]=1 and done[owner]=1.
  - xfer_count increments.
  - Next state is IDLE, with grant cleared on entry.
- ERR (1 cycle): err[owner]=1 and done[owner]=1. bus_valid=0 and ld_en=0. Next state is IDLE.
- Latency: req sampled in IDLE in cycle N gives bus_valid in N+1, ld_en/done in N+2, and IDLE again in N+3.
  - Best-case throughput is one transfer per 3 cycles.
  - An illegal request finishes in 2 cycles.
- Requesters drop req at the edge ending the done cycle. The arbiter does not re-examine a request while its transfer is in progress.
- If req falls during DRIVE/LOAD, the transfer still completes. There is no abort.
- Code inputs are sampled only in IDLE. Changes after the grant are ignored.
- src==dst is legal. It completes normally, counts, and pulses ld_en[dst].
- Outside DRIVE/LOAD, bus_sel holds its last value and bus_valid=0. Consumers qualify bus_sel with bus_valid.
- Simultaneous requests are served in round-robin order. A continuously asserted requester waits at most NREQ-1 transfers.
- xfer_count counts only LOAD cycles and wraps silently.

Test Plan:
1. Reset, then req=0001, src0=21 (mdr), dst0=3 (r3).
   - Required: bus_sel=21 and bus_valid=1 in cycle 1.
   - Required: ld_en=1<<3 and done=0001 in cycle 2, with xfer_count=1.
   - Required: grant=0 in cycle 3.
2. req=1111 held after each done, all legal codes, rr_ptr=0.
   - Required: grant order 0,1,2,3,0, with each transfer exactly 3 cycles apart.
3. req=0100, src2=30 (illegal), dst2=5.
   - Required: err=0100 and done=0100 in cycle 1.
   - Required: ld_en=0 and bus_valid=0 throughout, and xfer_count unchanged.
4. Start a legal transfer (src=20 pc, dst=23 Y) and assert clear=0 during DRIVE.
   - Required: all outputs 0 immediately, with no ld_en pulse.
   - Required: after release, req=0001 is granted first (rr_ptr=0).
5. Change src_code/dst_code of the granted requester during DRIVE (src 16->17).
   - Required: bus_sel stays 16 and ld_en targets the original dst.
6. Preload via 65535 legal transfers, then run one more.
   - Required: xfer_count goes 0xFFFF -> 0x0000.
